// File: rtl/riscvvec_vec_elem_sequencer_pkg.sv
// Shared constants for the vector element sequencer: FSM states, ALU function
// codes and default vector geometry.
package riscvvec_VecConsts;

  localparam int MAXVL_DEF = 32;
  localparam int IDXW_DEF  = 5;
  localparam int VLW_DEF   = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seqState_t;

  localparam logic [3:0] FN_ADD  = 4'd0;
  localparam logic [3:0] FN_SUB  = 4'd1;
  localparam logic [3:0] FN_SLL  = 4'd2;
  localparam logic [3:0] FN_OR   = 4'd3;
  localparam logic [3:0] FN_SLT  = 4'd4;
  localparam logic [3:0] FN_SLTU = 4'd5;
  localparam logic [3:0] FN_AND  = 4'd6;
  localparam logic [3:0] FN_XOR  = 4'd7;
  localparam logic [3:0] FN_NOR  = 4'd8;
  localparam logic [3:0] FN_SRL  = 4'd9;
  localparam logic [3:0] FN_SRA  = 4'd10;

  // Requested lengths beyond the register size are truncated to the register size.
  function automatic int unsigned clampVl(input int unsigned vl, input int unsigned maxvl);
    return (vl > maxvl) ? maxvl : vl;
  endfunction

endpackage

// File: rtl/riscvvec_vec_elem_sequencer_xreg.sv
// X-stage pipeline register: holds one element's ALU operands, its element
// index and a valid bit; everything freezes while stall is high.
module riscvvec_vec_elem_xreg #(
  parameter int IDXW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_stall,
  input  logic            i_load,
  input  logic            i_clear,
  input  logic [31:0]     i_in0,
  input  logic [31:0]     i_in1,
  input  logic [IDXW-1:0] i_idx,
  output logic [31:0]     o_in0,
  output logic [31:0]     o_in1,
  output logic [IDXW-1:0] o_idx,
  output logic            o_val
);

  logic [31:0]     r_in0;
  logic [31:0]     r_in1;
  logic [IDXW-1:0] r_idx;
  logic            r_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in0 <= '0;
      r_in1 <= '0;
      r_idx <= '0;
      r_val <= 1'b0;
    end else if (!i_stall) begin
      if (i_load) begin
        r_in0 <= i_in0;
        r_in1 <= i_in1;
        r_idx <= i_idx;
        r_val <= 1'b1;
      end else if (i_clear) begin
        r_val <= 1'b0;
      end
    end
  end

  assign o_in0 = r_in0;
  assign o_in1 = r_in1;
  assign o_idx = r_idx;
  assign o_val = r_val;

endmodule

// File: rtl/riscvvec_vec_elem_sequencer.sv
// Vector element sequencer: accepts one vector ALU instruction, streams its
// elements VRF -> ALU one per cycle and writes each result back to vd.
module riscvvec_vec_elem_sequencer
  import riscvvec_VecConsts::*;
#(
  parameter int MAXVL = MAXVL_DEF,
  parameter int IDXW  = IDXW_DEF,
  parameter int VLW   = VLW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_val,
  output logic            req_rdy,
  input  logic [3:0]      req_fn,
  input  logic [4:0]      req_vs1,
  input  logic [4:0]      req_vs2,
  input  logic [4:0]      req_vd,
  input  logic [VLW-1:0]  req_vl,
  input  logic            req_vx,
  input  logic [31:0]     req_scalar,
  output logic [4:0]      rf_raddr0,
  output logic [4:0]      rf_raddr1,
  output logic [IDXW-1:0] rf_ridx,
  input  logic [31:0]     rf_rdata0,
  input  logic [31:0]     rf_rdata1,
  output logic [31:0]     alu_in0,
  output logic [31:0]     alu_in1,
  output logic [3:0]      alu_fn,
  input  logic [31:0]     alu_out,
  output logic            rf_wen,
  output logic [4:0]      rf_waddr,
  output logic [IDXW-1:0] rf_widx,
  output logic [31:0]     rf_wdata,
  input  logic            stall,
  output logic            resp_val,
  input  logic            resp_rdy
);

  seqState_t       r_state;
  logic [3:0]      r_fn;
  logic [4:0]      r_vs1;
  logic [4:0]      r_vs2;
  logic [4:0]      r_vd;
  logic            r_vx;
  logic [31:0]     r_scalar;
  logic [VLW-1:0]  r_vlEff;
  logic [IDXW:0]   r_rdIdx;
  logic            r_reqRdy;
  logic            r_respVal;

  logic [VLW-1:0]  w_vlEff;
  logic            w_accept;
  logic            w_capture;
  logic            w_lastRead;
  logic            w_drainDone;
  logic [31:0]     w_in1Sel;
  logic [31:0]     w_xIn0;
  logic [31:0]     w_xIn1;
  logic [IDXW-1:0] w_xIdx;
  logic            w_xVal;

  assign w_vlEff     = VLW'(clampVl(32'(req_vl), MAXVL));
  assign w_accept    = req_val & r_reqRdy;
  assign w_capture   = (r_state == ST_RUN) & ~stall;
  assign w_lastRead  = w_capture & (32'(r_rdIdx) == (32'(r_vlEff) - 32'd1));
  assign w_drainDone = (r_state == ST_DRAIN) & ~stall;
  assign w_in1Sel    = r_vx ? r_scalar : rf_rdata1;

  // rd_idx carries one extra bit so a full-length vector ends without wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_fn      <= '0;
      r_vs1     <= '0;
      r_vs2     <= '0;
      r_vd      <= '0;
      r_vx      <= 1'b0;
      r_scalar  <= '0;
      r_vlEff   <= '0;
      r_rdIdx   <= '0;
      r_reqRdy  <= 1'b1;
      r_respVal <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_fn     <= req_fn;
            r_vs1    <= req_vs1;
            r_vs2    <= req_vs2;
            r_vd     <= req_vd;
            r_vx     <= req_vx;
            r_scalar <= req_scalar;
            r_vlEff  <= w_vlEff;
            r_rdIdx  <= '0;
            r_reqRdy <= 1'b0;
            if (w_vlEff == '0) begin
              r_state   <= ST_DONE;
              r_respVal <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (w_capture) begin
            r_rdIdx <= r_rdIdx + 1'b1;
            if (w_lastRead) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_drainDone) begin
            r_state   <= ST_DONE;
            r_respVal <= 1'b1;
          end
        end
        ST_DONE: begin
          if (resp_rdy) begin
            r_state   <= ST_IDLE;
            r_respVal <= 1'b0;
            r_reqRdy  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  riscvvec_vec_elem_xreg #(.IDXW(IDXW)) u_xreg (
    .clk     (clk),
    .reset   (reset),
    .i_stall (stall),
    .i_load  (w_capture),
    .i_clear (w_drainDone),
    .i_in0   (rf_rdata0),
    .i_in1   (w_in1Sel),
    .i_idx   (r_rdIdx[IDXW-1:0]),
    .o_in0   (w_xIn0),
    .o_in1   (w_xIn1),
    .o_idx   (w_xIdx),
    .o_val   (w_xVal)
  );

  assign req_rdy   = r_reqRdy;
  assign resp_val  = r_respVal;
  assign rf_raddr0 = r_vs1;
  assign rf_raddr1 = r_vs2;
  assign rf_ridx   = r_rdIdx[IDXW-1:0];
  assign alu_in0   = w_xIn0;
  assign alu_in1   = w_xIn1;
  assign alu_fn    = r_fn;
  assign rf_wen    = w_xVal & ~stall;
  assign rf_waddr  = r_vd;
  assign rf_widx   = w_xIdx;
  assign rf_wdata  = alu_out;

endmodule

// File: tb/tb_riscvvec_vec_elem_sequencer.sv
// Directed bench for the vector element sequencer with a behavioural VRF and ALU
// around it; every write-back is logged with its cycle number and checked.
module tb_riscvvec_vec_elem_sequencer;
  import riscvvec_VecConsts::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_val;
  logic        req_rdy;
  logic [3:0]  req_fn;
  logic [4:0]  req_vs1;
  logic [4:0]  req_vs2;
  logic [4:0]  req_vd;
  logic [5:0]  req_vl;
  logic        req_vx;
  logic [31:0] req_scalar;
  logic [4:0]  rf_raddr0;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_ridx;
  logic [31:0] rf_rdata0;
  logic [31:0] rf_rdata1;
  logic [31:0] alu_in0;
  logic [31:0] alu_in1;
  logic [3:0]  alu_fn;
  logic [31:0] alu_out;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [4:0]  rf_widx;
  logic [31:0] rf_wdata;
  logic        stall;
  logic        resp_val;
  logic        resp_rdy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int accCyc = 0;
  int respCyc = 0;
  int base = 0;

  logic [31:0] vrf [32][32];
  int          logCyc[$];
  int          logAddr[$];
  int          logIdx[$];
  logic [31:0] logData[$];

  riscvvec_vec_elem_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .req_val    (req_val),
    .req_rdy    (req_rdy),
    .req_fn     (req_fn),
    .req_vs1    (req_vs1),
    .req_vs2    (req_vs2),
    .req_vd     (req_vd),
    .req_vl     (req_vl),
    .req_vx     (req_vx),
    .req_scalar (req_scalar),
    .rf_raddr0  (rf_raddr0),
    .rf_raddr1  (rf_raddr1),
    .rf_ridx    (rf_ridx),
    .rf_rdata0  (rf_rdata0),
    .rf_rdata1  (rf_rdata1),
    .alu_in0    (alu_in0),
    .alu_in1    (alu_in1),
    .alu_fn     (alu_fn),
    .alu_out    (alu_out),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_widx    (rf_widx),
    .rf_wdata   (rf_wdata),
    .stall      (stall),
    .resp_val   (resp_val),
    .resp_rdy   (resp_rdy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign rf_rdata0 = vrf[rf_raddr0][rf_ridx];
  assign rf_rdata1 = vrf[rf_raddr1][rf_ridx];

  always_comb begin
    alu_out = 32'd0;
    case (alu_fn)
      FN_ADD:  alu_out = alu_in0 + alu_in1;
      FN_SUB:  alu_out = alu_in0 - alu_in1;
      FN_SLL:  alu_out = alu_in0 << alu_in1[4:0];
      FN_OR:   alu_out = alu_in0 | alu_in1;
      FN_SLT:  alu_out = {31'd0, $signed(alu_in0) < $signed(alu_in1)};
      FN_SLTU: alu_out = {31'd0, alu_in0 < alu_in1};
      FN_AND:  alu_out = alu_in0 & alu_in1;
      FN_XOR:  alu_out = alu_in0 ^ alu_in1;
      FN_NOR:  alu_out = ~(alu_in0 | alu_in1);
      FN_SRL:  alu_out = alu_in0 >> alu_in1[4:0];
      FN_SRA:  alu_out = $signed(alu_in0) >>> alu_in1[4:0];
      default: alu_out = 32'd0;
    endcase
  end

  // Write-backs are logged with the number of the cycle they complete.
  always @(posedge clk) begin
    if (rf_wen) begin
      logCyc.push_back(cyc);
      logAddr.push_back(int'(rf_waddr));
      logIdx.push_back(int'(rf_widx));
      logData.push_back(rf_wdata);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkWrite(input string tag, input int k, input int expCyc,
                            input int expAddr, input int expIdx, input logic [31:0] expData);
    if (k >= logIdx.size()) begin
      checkOutput({tag, "_missing"}, 32'(logIdx.size()), 32'(k + 1));
      return;
    end
    checkOutput({tag, "_cyc"},  32'(logCyc[k]),  32'(expCyc));
    checkOutput({tag, "_addr"}, 32'(logAddr[k]), 32'(expAddr));
    checkOutput({tag, "_idx"},  32'(logIdx[k]),  32'(expIdx));
    checkOutput({tag, "_data"}, logData[k],      expData);
  endtask

  // Presents one instruction; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input logic [3:0] fn, input int vs1, input int vs2, input int vd,
                               input int vl, input logic vx, input logic [31:0] scalar);
    @(negedge clk);
    req_fn     = fn;
    req_vs1    = 5'(vs1);
    req_vs2    = 5'(vs2);
    req_vd     = 5'(vd);
    req_vl     = 6'(vl);
    req_vx     = vx;
    req_scalar = scalar;
    req_val    = 1'b1;
    #2;
    checkOutput("req_rdy_idle", {31'd0, req_rdy}, 32'd1);
    @(posedge clk);
    accCyc = cyc;
    @(negedge clk);
    req_val = 1'b0;
  endtask

  // Called at a negedge; samples 2 time units later each cycle until resp_val.
  task automatic waitResp(input string tag, input int budget);
    for (int n = 0; n < budget; n++) begin
      #2;
      if (resp_val) break;
      @(negedge clk);
    end
    respCyc = cyc;
    checkOutput({tag, "_resp_seen"}, {31'd0, resp_val}, 32'd1);
  endtask

  task automatic finishResp(input string tag);
    @(negedge clk);
    #2;
    checkOutput({tag, "_rdy_after"},  {31'd0, req_rdy},  32'd1);
    checkOutput({tag, "_resp_after"}, {31'd0, resp_val}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] expSll [3];
    reset = 1'b1; req_val = 1'b0; req_fn = '0; req_vs1 = '0; req_vs2 = '0; req_vd = '0;
    req_vl = '0; req_vx = 1'b0; req_scalar = '0; stall = 1'b0; resp_rdy = 1'b1;
    for (int r = 0; r < 32; r++)
      for (int e = 0; e < 32; e++)
        vrf[r][e] = 32'hDEAD0000 + 32'(r * 32 + e);
    for (int e = 0; e < 4; e++) begin
      vrf[1][e] = 32'(e + 1);
      vrf[2][e] = 32'(10 * (e + 1));
    end
    for (int e = 0; e < 32; e++) begin
      vrf[4][e] = 32'(3 * e);
      vrf[6][e] = 32'd100;
      vrf[9][e] = 32'hFFFFFFFF;
      vrf[14][e] = 32'(e + 1);
      vrf[15][e] = 32'd0;
    end
    vrf[8][0] = 32'd1; vrf[8][1] = 32'd3; vrf[8][2] = 32'h80000000;
    for (int e = 0; e < 5; e++) begin
      vrf[10][e] = 32'(e + 1);
      vrf[11][e] = 32'(10 * (e + 1));
    end
    vrf[5][0] = 32'd7; vrf[5][1] = 32'd8; vrf[5][2] = 32'd9;
    vrf[13][0] = 32'd1; vrf[13][1] = 32'd1; vrf[13][2] = 32'd1;

    repeat (2) @(negedge clk);
    #2;
    checkOutput("rst_req_rdy",  {31'd0, req_rdy},  32'd1);
    checkOutput("rst_rf_wen",   {31'd0, rf_wen},   32'd0);
    checkOutput("rst_resp_val", {31'd0, resp_val}, 32'd0);
    checkOutput("rst_alu_in0",  alu_in0,           32'd0);
    checkOutput("rst_alu_in1",  alu_in1,           32'd0);
    checkOutput("rst_alu_fn",   {28'd0, alu_fn},   32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] vl=4 ADD");
    base = logIdx.size();
    applyStimulus(FN_ADD, 1, 2, 3, 4, 1'b0, 32'd0);
    waitResp("add4", 20);
    checkOutput("add4_resp_cyc", 32'(respCyc), 32'(accCyc + 6));
    checkOutput("add4_nwr", 32'(logIdx.size() - base), 32'd4);
    for (int i = 0; i < 4; i++)
      checkWrite("add4", base + i, accCyc + 2 + i, 3, i, 32'(11 * (i + 1)));
    finishResp("add4");

    $display("[TB] vl=0");
    base = logIdx.size();
    applyStimulus(FN_ADD, 1, 2, 3, 0, 1'b0, 32'd0);
    waitResp("vl0", 10);
    checkOutput("vl0_resp_cyc", 32'(respCyc), 32'(accCyc + 1));
    checkOutput("vl0_nwr", 32'(logIdx.size() - base), 32'd0);
    finishResp("vl0");

    $display("[TB] vl=40 clamps to 32");
    base = logIdx.size();
    applyStimulus(FN_ADD, 4, 6, 7, 40, 1'b0, 32'd0);
    waitResp("vl40", 60);
    checkOutput("vl40_resp_cyc", 32'(respCyc), 32'(accCyc + 34));
    checkOutput("vl40_nwr", 32'(logIdx.size() - base), 32'd32);
    for (int i = 0; i < 32; i++)
      checkWrite("vl40", base + i, accCyc + 2 + i, 7, i, 32'(3 * i + 100));
    finishResp("vl40");

    $display("[TB] vector-scalar SLL");
    expSll[0] = 32'd4; expSll[1] = 32'd12; expSll[2] = 32'd0;
    base = logIdx.size();
    applyStimulus(FN_SLL, 8, 9, 20, 3, 1'b1, 32'd2);
    waitResp("sll", 20);
    checkOutput("sll_nwr", 32'(logIdx.size() - base), 32'd3);
    for (int i = 0; i < 3; i++)
      checkWrite("sll", base + i, accCyc + 2 + i, 20, i, expSll[i]);
    finishResp("sll");

    $display("[TB] stall after second write");
    base = logIdx.size();
    applyStimulus(FN_ADD, 10, 11, 12, 5, 1'b0, 32'd0);
    repeat (3) @(negedge clk);
    stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #2;
      checkOutput("stall_wen", {31'd0, rf_wen}, 32'd0);
      @(negedge clk);
    end
    stall = 1'b0;
    waitResp("stall", 20);
    checkOutput("stall_resp_cyc", 32'(respCyc), 32'(accCyc + 10));
    checkOutput("stall_nwr", 32'(logIdx.size() - base), 32'd5);
    checkWrite("stall0", base + 0, accCyc + 2, 12, 0, 32'd11);
    checkWrite("stall1", base + 1, accCyc + 3, 12, 1, 32'd22);
    checkWrite("stall2", base + 2, accCyc + 7, 12, 2, 32'd33);
    checkWrite("stall3", base + 3, accCyc + 8, 12, 3, 32'd44);
    checkWrite("stall4", base + 4, accCyc + 9, 12, 4, 32'd55);
    finishResp("stall");

    $display("[TB] in-place SUB with held response");
    base = logIdx.size();
    resp_rdy = 1'b0;
    applyStimulus(FN_SUB, 5, 13, 5, 3, 1'b0, 32'd0);
    waitResp("inpl", 20);
    checkOutput("inpl_resp_cyc", 32'(respCyc), 32'(accCyc + 5));
    checkOutput("inpl_nwr", 32'(logIdx.size() - base), 32'd3);
    for (int i = 0; i < 3; i++)
      checkWrite("inpl", base + i, accCyc + 2 + i, 5, i, 32'(6 + i));
    for (int h = 0; h < 4; h++) begin
      @(negedge clk);
      #2;
      checkOutput("hold_resp_val", {31'd0, resp_val}, 32'd1);
      checkOutput("hold_req_rdy",  {31'd0, req_rdy},  32'd0);
    end
    resp_rdy = 1'b1;
    finishResp("inpl");

    $display("[TB] reset during third element");
    base = logIdx.size();
    applyStimulus(FN_ADD, 14, 15, 16, 8, 1'b0, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("mid_wen_before", {31'd0, rf_wen}, 32'd1);
    checkOutput("mid_widx_before", {27'd0, rf_widx}, 32'd2);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_wen",   {31'd0, rf_wen},   32'd0);
    checkOutput("mid_rst_resp",  {31'd0, resp_val}, 32'd0);
    checkOutput("mid_rst_rdy",   {31'd0, req_rdy},  32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checkOutput("mid_nwr", 32'(logIdx.size() - base), 32'd2);
    checkOutput("mid_no_resp", {31'd0, resp_val}, 32'd0);
    checkWrite("mid0", base + 0, accCyc + 2, 16, 0, 32'd1);
    checkWrite("mid1", base + 1, accCyc + 3, 16, 1, 32'd2);

    $display("[TB] clean instruction after reset");
    base = logIdx.size();
    applyStimulus(FN_ADD, 14, 15, 17, 3, 1'b0, 32'd0);
    waitResp("post", 20);
    checkOutput("post_nwr", 32'(logIdx.size() - base), 32'd3);
    for (int i = 0; i < 3; i++)
      checkWrite("post", base + i, accCyc + 2 + i, 17, i, 32'(i + 1));
    finishResp("post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
